// File: rtl/mmio_mailbox.sv
// Memory-mapped host<->CPU mailbox: rx/tx FIFOs, STATUS and DONE registers on the data-memory port.
// Optional registered interrupt output enabled by defining MAILBOX_IRQ_EN.
module mmio_mailbox #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        done
`ifdef MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  FULL = 5'(DEPTH);

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_RXDATA = 2'd1,
        REG_TXDATA = 2'd2,
        REG_DONE   = 2'd3
    } reg_sel_e;

    reg_sel_e sel;
    logic     wr;
    logic     rd;

    logic [31:0]   rx_mem [DEPTH];
    logic [PW-1:0] rx_wptr;
    logic [PW-1:0] rx_rptr;
    logic [4:0]    rx_count;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_under_set;
    logic          rx_underflow;

    logic [31:0]   tx_mem [DEPTH];
    logic [PW-1:0] tx_wptr;
    logic [PW-1:0] tx_rptr;
    logic [4:0]    tx_count;
    logic          tx_store;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_ovf_set;
    logic          tx_overflow;
    logic          tx_full;

    logic          status_wr;
    logic [31:0]   status;

    assign hit = (address >= BASE_ADDR) && (address <= (BASE_ADDR + 32'd15));
    assign sel = reg_sel_e'(address[3:2]);
    // A cycle with both strobes is a store; the load side is suppressed entirely.
    assign wr  = hit && memWrite;
    assign rd  = hit && memRead && !memWrite;

    assign in_ready     = (rx_count != FULL);
    assign rx_push      = in_valid && in_ready;
    assign rx_pop       = rd && (sel == REG_RXDATA) && (rx_count != '0);
    assign rx_under_set = rd && (sel == REG_RXDATA) && (rx_count == '0);

    assign out_valid  = (tx_count != '0);
    assign tx_full    = (tx_count == FULL);
    assign tx_pop     = out_valid && out_ready;
    assign tx_store   = wr && (sel == REG_TXDATA);
    // A host pop in the same cycle frees a slot, so a store to a full FIFO still lands.
    assign tx_push    = tx_store && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_store && tx_full && !tx_pop;
    assign out_data   = out_valid ? tx_mem[tx_rptr] : '0;

    assign status_wr = wr && (sel == REG_STATUS);
    assign status    = {18'd0, tx_count, rx_count, rx_underflow, tx_overflow, tx_full,
                        (rx_count != '0)};

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= in_data;
        end
        if (tx_push) begin
            tx_mem[tx_wptr] <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + PW'(1);
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + PW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 5'd1;
                2'b01:   rx_count <= rx_count - 5'd1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + PW'(1);
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + PW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 5'd1;
                2'b01:   tx_count <= tx_count - 5'd1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Sticky status bits: a set event in the same cycle beats a W1C clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
            done         <= 1'b0;
        end else begin
            tx_overflow  <= tx_ovf_set ||
                            (tx_overflow && !(status_wr && writeData[2]));
            rx_underflow <= rx_under_set ||
                            (rx_underflow && !(status_wr && writeData[3]));
            if (wr && (sel == REG_DONE)) begin
                done <= writeData[0];
            end
        end
    end

    always_comb begin
        readData = '0;
        if (rd) begin
            case (sel)
                REG_STATUS: readData = status;
                REG_RXDATA: readData = (rx_count != '0) ? rx_mem[rx_rptr] : '0;
                REG_TXDATA: readData = '0;
                REG_DONE:   readData = {31'd0, done};
                default:    readData = '0;
            endcase
        end
    end

`ifdef MAILBOX_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (rx_count != '0) || tx_overflow;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_mailbox.sv
// Directed bench for mmio_mailbox: a vector table for the register map plus hand sequences
// for streaming, full-FIFO corner cases, reset mid-transfer and (with MAILBOX_IRQ_EN) irq timing.
module tb_mmio_mailbox;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] A_STATUS = 32'h0000_1000;
    localparam logic [31:0] A_RX     = 32'h0000_1004;
    localparam logic [31:0] A_TX     = 32'h0000_1008;
    localparam logic [31:0] A_DONE   = 32'h0000_100C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        hit;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        done;
`ifdef MAILBOX_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_mailbox #(
        .DEPTH(DEPTH),
        .BASE_ADDR(32'h0000_1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memRead(memRead),
        .memWrite(memWrite),
        .address(address),
        .writeData(writeData),
        .readData(readData),
        .hit(hit),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .done(done)
`ifdef MAILBOX_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iv;
        logic [31:0] idata;
        logic        ordy;
        logic [31:0] e_rdata;
        logic        e_hit;
        logic        e_irdy;
        logic        e_oval;
        logic [31:0] e_odata;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic iv, input logic [31:0] idata,
                         input logic ordy);
        @(negedge clk);
        memRead   = rd;
        memWrite  = wr;
        address   = addr;
        writeData = wdata;
        in_valid  = iv;
        in_data   = idata;
        out_ready = ordy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic iv, input logic [31:0] idata,
                       input logic ordy, input logic [31:0] e_rdata, input logic e_hit,
                       input logic e_irdy, input logic e_oval, input logic [31:0] e_odata,
                       input logic e_done);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.iv = iv; v.idata = idata; v.ordy = ordy;
        v.e_rdata = e_rdata; v.e_hit = e_hit; v.e_irdy = e_irdy;
        v.e_oval = e_oval; v.e_odata = e_odata; v.e_done = e_done;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        memRead = 1'b0; memWrite = 1'b0; address = '0; writeData = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //  rd wr addr         wdata          iv idata  ordy  e_rdata      hit irdy oval odata done
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(0, 0, 32'h0,       0,             1, 10,    0,    32'h0,       0,  1,   0,   0,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h11,      1,  1,   0,   0,    0);
        add(1, 0, A_RX,        0,             0, 0,     0,    32'd10,      1,  1,   0,   0,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(0, 1, A_TX,        1,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(0, 1, A_TX,        2,             0, 0,     0,    32'h0,       1,  1,   1,   1,    0);
        add(0, 1, A_TX,        3,             0, 0,     0,    32'h0,       1,  1,   1,   1,    0);
        add(0, 1, A_TX,        5,             0, 0,     0,    32'h0,       1,  1,   1,   1,    0);
        add(0, 1, A_TX,        8,             0, 0,     0,    32'h0,       1,  1,   1,   1,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h806,     1,  1,   1,   1,    0);
        add(0, 0, 32'h0,       0,             0, 0,     0,    32'h0,       0,  1,   1,   1,    0);
        add(0, 0, 32'h0,       0,             0, 0,     1,    32'h0,       0,  1,   1,   1,    0);
        add(0, 0, 32'h0,       0,             0, 0,     0,    32'h0,       0,  1,   1,   2,    0);
        add(0, 0, 32'h0,       0,             0, 0,     1,    32'h0,       0,  1,   1,   2,    0);
        add(0, 0, 32'h0,       0,             0, 0,     0,    32'h0,       0,  1,   1,   3,    0);
        add(0, 0, 32'h0,       0,             0, 0,     1,    32'h0,       0,  1,   1,   3,    0);
        add(0, 0, 32'h0,       0,             0, 0,     0,    32'h0,       0,  1,   1,   5,    0);
        add(0, 0, 32'h0,       0,             0, 0,     1,    32'h0,       0,  1,   1,   5,    0);
        add(0, 0, 32'h0,       0,             0, 0,     0,    32'h0,       0,  1,   0,   0,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h4,       1,  1,   0,   0,    0);
        add(0, 1, A_STATUS,    32'h4,         0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(0, 1, A_DONE,      1,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, A_DONE,      0,             0, 0,     0,    32'h1,       1,  1,   0,   0,    1);
        add(0, 1, A_DONE,      32'hFFFF_FFFE, 0, 0,     0,    32'h0,       1,  1,   0,   0,    1);
        add(1, 0, A_DONE,      0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, A_RX,        0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h8,       1,  1,   0,   0,    0);
        add(0, 1, A_STATUS,    32'h8,         0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, 32'h1014,    0,             0, 0,     0,    32'h0,       0,  1,   0,   0,    0);
        add(1, 0, A_STATUS,    0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(0, 1, 32'h100F,    1,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, 32'h100D,    0,             0, 0,     0,    32'h1,       1,  1,   0,   0,    1);
        add(1, 0, A_TX,        0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    1);
        add(1, 1, A_DONE,      0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    1);
        add(1, 0, A_DONE,      0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);
        add(1, 0, 32'h0FFC,    0,             0, 0,     0,    32'h0,       0,  1,   0,   0,    0);
        add(0, 1, 32'h1010,    1,             0, 0,     0,    32'h0,       0,  1,   0,   0,    0);
        add(1, 0, A_DONE,      0,             0, 0,     0,    32'h0,       1,  1,   0,   0,    0);

        idle();
        idle();
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                  tbl[i].iv, tbl[i].idata, tbl[i].ordy);
            chk($sformatf("v%0d readData", i), readData, tbl[i].e_rdata);
            chk($sformatf("v%0d hit", i), 32'(hit), 32'(tbl[i].e_hit));
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_oval));
            chk($sformatf("v%0d out_data", i), out_data, tbl[i].e_odata);
            chk($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].e_done));
        end

        // rx streaming: host pushes every cycle while the CPU pops every cycle after the first
        for (int i = 0; i <= int'(DEPTH); i++) begin
            drive(i > 0, 1'b0, (i > 0) ? A_RX : 32'h0, 32'h0, 1'b1, 32'(100 + i), 1'b0);
            chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'h1);
            if (i > 0) chk($sformatf("stream%0d data", i), readData, 32'(100 + i - 1));
        end
        drive(1'b1, 1'b0, A_RX, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("stream last", readData, 32'(100 + DEPTH));
        drive(1'b1, 1'b0, A_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("stream status", readData, 32'h0);

        // rx full: offered push is refused, concurrent pop proceeds
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'(201 + i), 1'b0);
            chk($sformatf("rxfill%0d in_ready", i), 32'(in_ready), 32'h1);
        end
        drive(1'b1, 1'b0, A_RX, 32'h0, 1'b1, 32'd205, 1'b0);
        chk("rxfull in_ready", 32'(in_ready), 32'h0);
        chk("rxfull pop data", readData, 32'd201);
        drive(1'b1, 1'b0, A_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rxfull status", readData, 32'h31);
        for (int j = 0; j < int'(DEPTH) - 1; j++) begin
            drive(1'b1, 1'b0, A_RX, 32'h0, 1'b0, 32'h0, 1'b0);
            chk($sformatf("rxdrain%0d", j), readData, 32'(202 + j));
        end
        drive(1'b1, 1'b0, A_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rxdrain status", readData, 32'h0);

        // tx full: store in the same cycle as a host pop is accepted without overflow
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b0, 1'b1, A_TX, 32'(11 + i), 1'b0, 32'h0, 1'b0);
        end
        drive(1'b0, 1'b1, A_TX, 32'd15, 1'b0, 32'h0, 1'b1);
        chk("txfull out_data", out_data, 32'd11);
        drive(1'b1, 1'b0, A_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("txfull status", readData, 32'h802);
        for (int j = 0; j < int'(DEPTH); j++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
            chk($sformatf("txdrain%0d", j), out_data, 32'(12 + j));
        end
        idle();
        chk("txdrain out_valid", 32'(out_valid), 32'h0);
        drive(1'b1, 1'b0, A_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("txdrain status", readData, 32'h0);

        // reset with both FIFOs half full and transfers in flight
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd2, 1'b0);
        drive(1'b0, 1'b1, A_TX, 32'd7, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, A_TX, 32'd8, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, A_DONE, 32'd1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, A_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("prereset status", readData, 32'h421);
        drive(1'b0, 1'b1, A_TX, 32'd9, 1'b1, 32'd3, 1'b1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'h1);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst done", 32'(done), 32'h0);
        drive(1'b1, 1'b0, A_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst status", readData, 32'h0);

`ifdef MAILBOX_IRQ_EN
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd50, 1'b0);
        chk("irq idle", 32'(irq), 32'h0);
        idle();
        chk("irq not yet", 32'(irq), 32'h0);
        idle();
        chk("irq set", 32'(irq), 32'h1);
        drive(1'b1, 1'b0, A_RX, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("irq pop data", readData, 32'd50);
        idle();
        chk("irq held", 32'(irq), 32'h1);
        idle();
        chk("irq clear", 32'(irq), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
